// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
package lm_sm_sequencer_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RIDX_W = 3;

  // R7 is the PC and never a transfer target, so only R0..R6 are tracked.
  localparam logic [2:0]  PC_IDX  = 3'd7;
  localparam int unsigned PMASK_W = 32'(PC_IDX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lm_sm_sequencer_prio_enc7.sv
// Lowest-set-bit priority encoder over a 7-bit register mask.
module prio_enc7 (
  input  logic [6:0] mask,
  output logic [2:0] idx,
  output logic       any
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    any = |mask;
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a register mask low to high, one memory transfer per register.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RIDX_W = DEF_RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [7:0]        reg_mask,
  output logic              busy,
  output logic              done,
  output logic [RIDX_W-1:0] rf_read_address,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [RIDX_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t               state, state_d;
  logic [PMASK_W-1:0]   pend_mask, pend_d, cur_onehot, pend_cleared;
  logic [DATA_W-1:0]    cur_addr, addr_d;
  logic                 op_load, op_d;
  logic [2:0]           cur_idx;
  logic                 pend_any;
  logic                 unused_pc_bit;

  assign unused_pc_bit = reg_mask[PC_IDX];

  prio_enc7 u_prio (
    .mask (pend_mask),
    .idx  (cur_idx),
    .any  (pend_any)
  );

  assign cur_onehot   = PMASK_W'(1) << cur_idx;
  assign pend_cleared = pend_mask & ~cur_onehot;

  assign rf_read_address  = RIDX_W'(cur_idx);
  assign rf_write_address = RIDX_W'(cur_idx);
  assign rf_write_data    = mem_rdata;
  assign mem_addr         = cur_addr;
  assign mem_wdata        = rf_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pend_mask <= '0;
      cur_addr  <= '0;
      op_load   <= 1'b0;
    end else begin
      state     <= state_d;
      pend_mask <= pend_d;
      cur_addr  <= addr_d;
      op_load   <= op_d;
    end
  end

  // Next-state and strobes; all outputs derive from reset-cleared state, so rst drops them at once.
  always_comb begin
    state_d     = state;
    pend_d      = pend_mask;
    addr_d      = cur_addr;
    op_d        = op_load;
    busy        = 1'b0;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_write_en = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          pend_d  = reg_mask[PMASK_W-1:0];
          addr_d  = base_addr;
          op_d    = is_load;
          state_d = (reg_mask[PMASK_W-1:0] != '0) ? ST_ACCESS : ST_DONE;
        end else if (state == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        busy    = 1'b1;
        mem_req = pend_any;
        mem_we  = pend_any & ~op_load;
        if (mem_ack) begin
          rf_write_en = op_load;
          pend_d      = pend_cleared;
          addr_d      = cur_addr + DATA_W'(1);
          if (pend_cleared == '0) state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: stimulus pushes expected transfers, monitor acks and checks.
module tb_lm_sm_sequencer;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
    logic [2:0]  idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        busy;
  logic        done;
  logic [2:0]  rf_read_address;
  logic [15:0] rf_read_data;
  logic        rf_write_en;
  logic [2:0]  rf_write_address;
  logic [15:0] rf_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic [15:0] rf_img [8];
  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          req_cnt = 0;
  int          commit_cnt = 0;
  int          stall_req = 0;

  lm_sm_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .is_load          (is_load),
    .base_addr        (base_addr),
    .reg_mask         (reg_mask),
    .busy             (busy),
    .done             (done),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data),
    .rf_write_en      (rf_write_en),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_read_data = rf_img[rf_read_address];
  assign mem_rdata    = mem_addr + 16'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [15:0] a, input logic we, input logic [15:0] d, input logic [2:0] idx);
    exp_t e;
    e.addr = a; e.we = we; e.data = d; e.idx = idx;
    q.push_back(e);
  endtask

  // Register-file commit counter: an LM write lands on the edge ending the ack cycle.
  always @(posedge clk) begin
    if (rf_write_en) commit_cnt++;
  end

  // Memory responder + monitor: drives mem_ack, checks each acked transfer against the queue.
  initial begin : monitor
    logic prev_req;
    int   stall_left;
    exp_t e;
    prev_req   = 1'b0;
    stall_left = 0;
    mem_ack    = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) stall_left = stall_req;
      if (mem_req && stall_left > 0) begin
        mem_ack = 1'b0;
        stall_left--;
      end else begin
        mem_ack = mem_req;
      end
      prev_req = mem_req;
      #1;
      if (rst) q.delete();
      if (mem_req) req_cnt++;
      if (mem_req && !mem_ack) begin
        chk("stall_wen", 32'(rf_write_en), 32'd0);
        if (q.size() > 0) chk("stall_addr", 32'(mem_addr), 32'(q[0].addr));
      end else if (mem_req && mem_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_xfer", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("xfer_addr", 32'(mem_addr), 32'(e.addr));
          chk("xfer_we", 32'(mem_we), 32'(e.we));
          if (e.we) begin
            chk("store_data", 32'(mem_wdata), 32'(e.data));
            chk("store_ridx", 32'(rf_read_address), 32'(e.idx));
            chk("store_wen", 32'(rf_write_en), 32'd0);
          end else begin
            chk("load_wen", 32'(rf_write_en), 32'd1);
            chk("load_widx", 32'(rf_write_address), 32'(e.idx));
            chk("load_wdata", 32'(rf_write_data), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic issue(input logic ld, input logic [15:0] base, input logic [7:0] mask);
    is_load   = ld;
    base_addr = base;
    reg_mask  = mask;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done is seen; 0 means it never came.
  task automatic wait_done(input string name, input int exp_k);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      #2;
      if (done) begin
        k = i;
        break;
      end
    end
    chk(name, 32'(k), 32'(exp_k));
    chk({name, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  initial begin : stim
    int c0, r0;
    rst = 1'b1; start = 1'b0; is_load = 1'b0; base_addr = '0; reg_mask = '0;
    for (int i = 0; i < 8; i++) rf_img[i] = 16'h0000;
    rf_img[0] = 16'h0A0A; rf_img[1] = 16'h0B0B;
    rf_img[3] = 16'h1234; rf_img[6] = 16'hBEEF;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wen", 32'(rf_write_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ridx", 32'(rf_read_address), 32'd0);
    chk("rst_widx", 32'(rf_write_address), 32'd0);
    rst = 1'b0;

    // LM R0,R2 from 0x0100
    @(negedge clk);
    c0 = commit_cnt; r0 = req_cnt;
    push(16'h0100, 1'b0, 16'h1100, 3'd0);
    push(16'h0101, 1'b0, 16'h1101, 3'd2);
    issue(1'b1, 16'h0100, 8'b0000_0101);
    wait_done("lm2_done", 3);
    chk("lm2_commits", 32'(commit_cnt - c0), 32'd2);
    chk("lm2_reqs", 32'(req_cnt - r0), 32'd2);
    chk("lm2_busy_in_done", 32'(busy), 32'd0);

    // SM R3,R6 to 0x0200
    @(negedge clk);
    c0 = commit_cnt;
    push(16'h0200, 1'b1, 16'h1234, 3'd3);
    push(16'h0201, 1'b1, 16'hBEEF, 3'd6);
    issue(1'b0, 16'h0200, 8'b0100_1000);
    wait_done("sm2_done", 3);
    chk("sm2_commits", 32'(commit_cnt - c0), 32'd0);

    // Only R7 selected: nothing to transfer
    @(negedge clk);
    c0 = commit_cnt; r0 = req_cnt;
    issue(1'b1, 16'h0300, 8'b1000_0000);
    wait_done("pc_only_done", 1);
    chk("pc_only_reqs", 32'(req_cnt - r0), 32'd0);
    chk("pc_only_commits", 32'(commit_cnt - c0), 32'd0);

    // LM R1,R2 with a 3-cycle wait on the first transfer
    @(negedge clk);
    c0 = commit_cnt; r0 = req_cnt;
    stall_req = 3;
    push(16'h0500, 1'b0, 16'h1500, 3'd1);
    push(16'h0501, 1'b0, 16'h1501, 3'd2);
    issue(1'b1, 16'h0500, 8'b0000_0110);
    wait_done("stall_done", 6);
    stall_req = 0;
    chk("stall_reqs", 32'(req_cnt - r0), 32'd5);
    chk("stall_commits", 32'(commit_cnt - c0), 32'd2);

    // SM R0,R1 across the address wrap
    @(negedge clk);
    push(16'hFFFF, 1'b1, 16'h0A0A, 3'd0);
    push(16'h0000, 1'b1, 16'h0B0B, 3'd1);
    issue(1'b0, 16'hFFFF, 8'b0000_0011);
    wait_done("wrap_done", 3);

    // Start raised during DONE chains straight into the next op
    @(negedge clk);
    push(16'h0600, 1'b0, 16'h1600, 3'd0);
    issue(1'b1, 16'h0600, 8'b0000_0001);
    wait_done("chain1_done", 2);
    push(16'h0700, 1'b1, 16'h0A0A, 3'd0);
    issue(1'b0, 16'h0700, 8'b0000_0001);
    wait_done("chain2_done", 2);

    // Reset during the second ACCESS cycle of a 4-register LM
    @(negedge clk);
    c0 = commit_cnt;
    push(16'h0300, 1'b0, 16'h1300, 3'd0);
    push(16'h0301, 1'b0, 16'h1301, 3'd1);
    push(16'h0302, 1'b0, 16'h1302, 3'd2);
    push(16'h0303, 1'b0, 16'h1303, 3'd3);
    issue(1'b1, 16'h0300, 8'b0000_1111);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_wen", 32'(rf_write_en), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_widx", 32'(rf_write_address), 32'd0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    chk("midrst_commits", 32'(commit_cnt - c0), 32'd1);

    // Fresh LM R1,R4 after reset
    @(negedge clk);
    c0 = commit_cnt;
    push(16'h0400, 1'b0, 16'h1400, 3'd1);
    push(16'h0401, 1'b0, 16'h1401, 3'd4);
    issue(1'b1, 16'h0400, 8'b0001_0010);
    wait_done("post_rst_done", 3);
    chk("post_rst_commits", 32'(commit_cnt - c0), 32'd2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
